// File: rtl/pll_reset_sequencer.sv
// Purpose : PLL reset/lock supervisor; pulses PLL reset, waits for debounced lock with
//           timeout and bounded retries, then releases downstream reset.
// Latency : pll_locked -> lock_s 2 cycles; outputs registered, change with state.
// Backpress: none; inputs sampled every refclk cycle, restart is a 1-cycle pulse.
//
// Ports:
//   refclk      free-running reference clock (also feeds the PLL)
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock indication, asynchronous to refclk
//   restart     single-cycle request to re-sequence from any state
//   pll_rst     PLL reset, active-high
//   sys_rst_n   downstream clock-domain reset, active-low (high only in RUN)
//   ready       high only in RUN
//   fault       high only in FAULT
//   state       current state code
//   retry_cnt   lock timeouts in the current sequence
//   loss_cnt    (only with PLL_SEQ_LOSS_CNT_EN) saturating count of lock losses in RUN
//
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3,
  localparam int RETRY_W     = $clog2(MAX_RETRIES + 1)
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ASSERT = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // Counter widths hold the largest value each counter reaches (terminal count - 1).
  localparam int RST_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;

  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]   STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               sync_q, lock_s_q;
  logic [2:0]         state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_sat;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               pll_rst_q, pll_rst_d;
  logic               run_q, run_d;
  logic               fault_q, fault_d;
  logic               tmo_hit;

  // Two-flop synchronizer for the asynchronous lock signal.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      lock_s_q <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;
    // Timeout counter saturates so a long bounce in STABLE cannot wrap it.
    tmo_sat   = (tmo_cnt_q == TMO_LAST) ? TMO_LAST : tmo_cnt_q + 1'b1;
    tmo_hit   = (tmo_cnt_q == TMO_LAST) && !lock_s_q;
    retry_inc = retry_q + 1'b1;

    if (restart) begin
      state_d   = S_ASSERT;
      rst_cnt_d = '0;
      tmo_cnt_d = '0;
      stb_cnt_d = '0;
      retry_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_ASSERT;
          rst_cnt_d = '0;
        end
        S_ASSERT: begin
          tmo_cnt_d = '0;
          if (rst_cnt_q == RST_LAST) state_d = S_WAIT;
          else                       rst_cnt_d = rst_cnt_q + 1'b1;
        end
        S_WAIT, S_STABLE: begin
          tmo_cnt_d = tmo_sat;
          if (tmo_hit) begin
            retry_d   = retry_inc;
            rst_cnt_d = '0;
            state_d   = (retry_inc == RETRY_MAX) ? S_FAULT : S_ASSERT;
          end else if (state_q == S_WAIT) begin
            if (lock_s_q) begin
              state_d   = S_STABLE;
              stb_cnt_d = '0;
            end
          end else if (!lock_s_q) begin
            state_d   = S_WAIT;
            stb_cnt_d = '0;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end else begin
            stb_cnt_d = stb_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d   = S_ASSERT;
            rst_cnt_d = '0;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs decoded from the next state so they flip on the same edge as state.
    pll_rst_d = (state_d == S_IDLE) || (state_d == S_ASSERT) || (state_d == S_FAULT);
    run_d     = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      stb_cnt_q <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      run_q     <= run_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = run_q;
  assign ready     = run_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  // Counts lock losses that drop RUN; survives restart, cleared only by rst_n.
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       loss_evt;

  always_comb begin
    loss_evt   = !restart && (state_q == S_RUN) && !lock_s_q;
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= 8'd0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose : directed self-checking bench for pll_reset_sequencer.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpress: n/a.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  pll_reset_sequencer #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .MAX_RETRIES (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault     (fault),
    .state     (state),
    .retry_cnt (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #3 rst_n   = 1'b0;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("rst_loss", loss_cnt, 0);
`endif

    // Bring-up: IDLE for one cycle, ASSERT for exactly 4 cycles.
    rst_n = 1'b1;
    tick(1);
    chk("up_assert", state, 1);
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++;
      tick(1);
    end
    chk("up_rst_len", n, 4);
    chk("up_wait", state, 2);
    tick(5);
    pll_locked = 1'b1;
    tick(2);
    chk("up_still_wait", state, 2);
    tick(1);
    chk("up_stable", state, 3);
    tick(7);
    chk("up_stable_end", state, 3);
    chk("up_sys_rst_held", sys_rst_n, 0);
    tick(1);
    chk("up_run", state, 4);
    chk("up_sys_rst_n", sys_rst_n, 1);
    chk("up_ready", ready, 1);
    chk("up_retry", retry_cnt, 0);
    chk("up_pll_rst", pll_rst, 0);

    // Lock loss in RUN: reaction exactly 3 edges later.
    pll_locked = 1'b0;
    tick(2);
    chk("loss_e2_sys", sys_rst_n, 1);
    chk("loss_e2_pll", pll_rst, 0);
    tick(1);
    chk("loss_e3_state", state, 1);
    chk("loss_e3_sys", sys_rst_n, 0);
    chk("loss_e3_pll", pll_rst, 1);
    chk("loss_e3_retry", retry_cnt, 0);
    pll_locked = 1'b1;
    tick(4);
    chk("loss_wait", state, 2);
    tick(1);
    chk("loss_stable", state, 3);
    tick(8);
    chk("loss_run", state, 4);
    chk("loss_run_sys", sys_rst_n, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt1", loss_cnt, 1);
`endif

    // Restart from RUN, then a 1-cycle lock glitch at stable count 5.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs_assert", state, 1);
    chk("rs_ready", ready, 0);
    tick(3);
    chk("rs_assert_end", state, 1);
    tick(1);
    chk("rs_wait", state, 2);
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("gl_stable5", state, 3);
    tick(1);
    chk("gl_back_wait", state, 2);
    tick(1);
    chk("gl_stable_again", state, 3);
    tick(7);
    chk("gl_fresh_count", state, 3);
    tick(1);
    chk("gl_run", state, 4);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("gl_loss_cnt", loss_cnt, 1);
`endif

    // Lock lost for good: two timeout rounds then FAULT.
    pll_locked = 1'b0;
    tick(3);
    chk("to_assert", state, 1);
    tick(4);
    chk("to_wait1", state, 2);
    tick(19);
    chk("to_wait1_end", state, 2);
    chk("to_retry0", retry_cnt, 0);
    tick(1);
    chk("to_retry_assert", state, 1);
    chk("to_retry1", retry_cnt, 1);
    tick(4);
    chk("to_wait2", state, 2);
    tick(19);
    chk("to_wait2_end", state, 2);
    tick(1);
    chk("to_fault", state, 5);
    chk("to_fault_retry", retry_cnt, 2);
    chk("to_fault_flag", fault, 1);
    chk("to_fault_pll", pll_rst, 1);
    chk("to_fault_sys", sys_rst_n, 0);
    tick(5);
    chk("to_fault_hold", state, 5);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("fr_assert", state, 1);
    chk("fr_retry", retry_cnt, 0);
    chk("fr_fault", fault, 0);
    chk("fr_pll_rst", pll_rst, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("fr_loss_kept", loss_cnt, 2);
`endif

    // Restart coincident with a timeout wins: ASSERT with retry_cnt 0.
    tick(4);
    chk("co_wait", state, 2);
    tick(19);
    chk("co_wait_end", state, 2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("co_assert", state, 1);
    chk("co_retry", retry_cnt, 0);

    // One timeout, then async reset in the middle of WAIT_LOCK.
    tick(4);
    chk("ar_wait", state, 2);
    tick(20);
    chk("ar_assert", state, 1);
    chk("ar_retry1", retry_cnt, 1);
    tick(4);
    chk("ar_wait2", state, 2);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_pll_rst", pll_rst, 1);
    chk("ar_sys_rst_n", sys_rst_n, 0);
    chk("ar_retry", retry_cnt, 0);
    chk("ar_fault", fault, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("ar_loss", loss_cnt, 0);
`endif

    // Recover to RUN with a steady lock.
    tick(2);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    chk("rec_ready", ready, 1);
    chk("rec_cycles", n, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the on-chip PLL: holds the PLL in reset for a guaranteed minimum pulse, waits for `locked` with a timeout and bounded retries, debounces lock, and only then releases the reset of the downstream clock domains. It runs on the free-running 50 MHz reference clock that also feeds the PLL. It sits between board reset and everything clocked by `outclk_0`/`outclk_1`. If lock is lost while running, it re-sequences automatically.

## Interface
- `RST_CYCLES`, 16: PLL reset pulse length in refclk cycles, ≥1.
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before a retry (1 ms).
- `LOCK_STABLE`, 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 3: timeouts tolerated before FAULT, ≥1.
- Counter widths are `$clog2` of the largest value each counter must hold.

- `refclk` in 1: sole clock, PLL reference clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to refclk.
- `restart` in 1: single-cycle request to re-sequence from any state.
- `pll_rst` out 1: drives PLL `rst`, active-high.
- `sys_rst_n` out 1: downstream domain reset, active-low.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `state` out 3: current state encoding.
- `retry_cnt` out $clog2(MAX_RETRIES+1): timeouts in the current sequence.

## Operation
- `pll_locked` passes through a 2-FF synchronizer. The FSM sees only `lock_s`.
- States: IDLE=0, ASSERT=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5. Codes 6 and 7 go to IDLE.
- IDLE → ASSERT unconditionally after one cycle.
- ASSERT: `pll_rst`=1 for exactly RST_CYCLES cycles, then → WAIT_LOCK. The timeout counter clears on entry.
- WAIT_LOCK: `pll_rst`=0 and the timeout counter increments.
  - `lock_s`=1 → STABLE with the stable counter cleared.
  - If the timeout counter reaches LOCK_TIMEOUT−1 with `lock_s`=0, `retry_cnt` increments.
  - If the new value equals MAX_RETRIES → FAULT, otherwise → ASSERT.
- STABLE: the stable counter increments while `lock_s`=1, and the timeout counter keeps running.
  - Counter reaches LOCK_STABLE−1 → RUN.
  - `lock_s`=0 → WAIT_LOCK with the stable counter cleared.
  - Timeout expiry here is handled exactly as in WAIT_LOCK.
- RUN: `sys_rst_n`=1, `ready`=1, `retry_cnt` cleared on entry. `lock_s`=0 → ASSERT, with `retry_cnt` staying 0.
- FAULT: `pll_rst`=1, `fault`=1, `sys_rst_n`=0. This state is left only via `restart` or `rst_n`.
- `restart`=1 in any state → ASSERT next cycle, with `retry_cnt` and all counters cleared. It takes priority over every other transition, including a same-cycle lock loss or timeout.
- `sys_rst_n` is 0 in every state except RUN.

## Timing
- Reset values: state=IDLE, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, all counters 0, synchronizer 0.
- All outputs are registered and decoded from the registered next state, so they change on the same edge as `state`.
- Latency from a `pll_locked` edge to the `lock_s` edge: 2 cycles.
- Lock loss in RUN: `sys_rst_n` falls and `pll_rst` rises 3 edges after `pll_locked` falls (2 synchronizer + 1 FSM).
- Minimum time from `lock_s` rising in WAIT_LOCK to `sys_rst_n` rising: LOCK_STABLE+1 cycles.
- `rst_n` assertion mid-sequence forces reset values asynchronously, with no glitch on `pll_rst` (it goes to 1).

## Configuration
- `PLL_SEQ_LOSS_CNT_EN` defined: adds output `loss_cnt` [7:0].
  - Increments, saturating at 255, on each RUN→ASSERT transition caused by lock loss.
  - Cleared only by `rst_n`, not by `restart`.
- Undefined: no `loss_cnt` port and no counter logic.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
- Release `rst_n`, raise `pll_locked` 5 cycles after `pll_rst` falls → `pll_rst` high for exactly 4 cycles; RUN entered after 8 stable cycles; `sys_rst_n`=1, `ready`=1, `retry_cnt`=0.
- `pll_locked` held 0 → two ASSERT/WAIT_LOCK rounds of 20 cycles each, then FAULT with `retry_cnt`=2, `fault`=1, `pll_rst`=1; `restart` pulse → ASSERT, `retry_cnt`=0.
- In STABLE, drop `pll_locked` for 1 cycle at stable count 5 → back to WAIT_LOCK; RUN needs a fresh 8 consecutive cycles.
- In RUN, drop `pll_locked` → `sys_rst_n`=0 and `pll_rst`=1 exactly 3 edges later, then a full resequence back to RUN; with the macro defined, `loss_cnt`=1.
- Assert `rst_n` mid-WAIT_LOCK → immediate reset values; `restart` coincident with a timeout → ASSERT with `retry_cnt`=0.
